// File: rtl/csel_add_pipe.sv
// Pipelined carry-select adder with valid/ready handshakes; latency PIPE+1 cycles, one beat per cycle.
// in_ready depends only on internal valids and out_ready, so a full pipe accepts while it emits.
module csel_add_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB = WIDTH / BLOCK;

  typedef logic [NB-1:0][BLOCK:0] cand_t;

  cand_t pre0;
  cand_t pre1;
  cand_t sel0;
  cand_t sel1;
  logic  mid_vld;

  // Block 0 already folds cin in, so both candidates hold the same value and the
  // chain below can treat every block uniformly with a zero carry into block 0.
  always_comb begin
    pre0    = '0;
    pre1    = '0;
    pre0[0] = {1'b0, a[BLOCK-1:0]} + {1'b0, b[BLOCK-1:0]} + {{BLOCK{1'b0}}, cin};
    pre1[0] = pre0[0];
    for (int k = 1; k < NB; k++) begin
      pre0[k] = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, b[k*BLOCK +: BLOCK]};
      pre1[k] = pre0[k] + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             chain_c;
  logic [BLOCK:0]   chain_blk;

  always_comb begin
    sum_d     = '0;
    chain_c   = 1'b0;
    chain_blk = '0;
    for (int k = 0; k < NB; k++) begin
      chain_blk                 = chain_c ? sel1[k] : sel0[k];
      sum_d[k*BLOCK +: BLOCK]   = chain_blk[BLOCK-1:0];
      chain_c                   = chain_blk[BLOCK];
    end
    cout_d = chain_c;
  end

  logic             ov_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_load;

  assign out_load = !ov_q || out_ready;

  generate
    if (PIPE != 0) begin : g_pipe
      logic  v1_q;
      cand_t p0_q;
      cand_t p1_q;

      assign in_ready = !v1_q || out_load;
      assign sel0     = p0_q;
      assign sel1     = p1_q;
      assign mid_vld  = v1_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1_q <= 1'b0;
          p0_q <= '0;
          p1_q <= '0;
        end else begin
          if (in_ready) v1_q <= in_valid;
          if (in_valid && in_ready) begin
            p0_q <= pre0;
            p1_q <= pre1;
          end
        end
      end
    end else begin : g_flat
      assign in_ready = out_load;
      assign sel0     = pre0;
      assign sel1     = pre1;
      assign mid_vld  = in_valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      if (out_load) ov_q <= mid_vld;
      if (out_load && mid_vld) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_csel_add_pipe.sv
// Bench for csel_add_pipe: directed handshake scenarios on a (16,4,1) instance plus
// randomised scoreboard runs on (16,4,1), (8,1,0) and (32,8,1) instances.
module tb_csel_add_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic        p1_iv, p1_ir, p1_ic, p1_ov, p1_or, p1_co;
  logic [15:0] p1_a, p1_b, p1_s;
  logic        p0_iv, p0_ir, p0_ic, p0_ov, p0_or, p0_co;
  logic [7:0]  p0_a, p0_b, p0_s;
  logic        w_iv, w_ir, w_ic, w_ov, w_or, w_co;
  logic [31:0] w_a, w_b, w_s;

  csel_add_pipe #(.WIDTH(16), .BLOCK(4), .PIPE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(p1_iv), .in_ready(p1_ir), .a(p1_a), .b(p1_b),
    .cin(p1_ic), .out_valid(p1_ov), .out_ready(p1_or), .sum(p1_s), .cout(p1_co));

  csel_add_pipe #(.WIDTH(8), .BLOCK(1), .PIPE(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(p0_iv), .in_ready(p0_ir), .a(p0_a), .b(p0_b),
    .cin(p0_ic), .out_valid(p0_ov), .out_ready(p0_or), .sum(p0_s), .cout(p0_co));

  csel_add_pipe #(.WIDTH(32), .BLOCK(8), .PIPE(1)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b),
    .cin(w_ic), .out_valid(w_ov), .out_ready(w_or), .sum(w_s), .cout(w_co));

  // Drive one cycle on the main instance at the falling edge, then let outputs settle.
  task automatic drv(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic ordy);
    @(negedge clk);
    p1_iv = v; p1_a = a; p1_b = b; p1_ic = c; p1_or = ordy;
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    p1_iv = 1'b1; p1_a = 16'($urandom); p1_b = 16'($urandom); p1_ic = 1'b1; p1_or = 1'b1;
    p0_iv = 1'b1; p0_a = 8'($urandom); p0_b = 8'($urandom); p0_ic = 1'b1; p0_or = 1'b1;
    w_iv = 1'b1; w_a = $urandom; w_b = $urandom; w_ic = 1'b1; w_or = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_run++;
    if (p1_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", p1_ov); end
    n_run++;
    if (p1_s !== 16'h0000 || p1_co !== 1'b0) begin
      n_fail++; $display("FAIL reset_sum: got %b/%h want 0/0000", p1_co, p1_s);
    end
    n_run++;
    if (p1_ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", p1_ir); end
    n_run++;
    if (p0_ov !== 1'b0 || w_ov !== 1'b0) begin
      n_fail++; $display("FAIL reset_other_valid: got %b,%b want 0,0", p0_ov, w_ov);
    end
    @(negedge clk);
    p1_iv = 1'b0; p0_iv = 1'b0; w_iv = 1'b0;
    rst_n = 1'b1;
    #1;
    n_run++;
    if (p1_ir !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", p1_ir); end
    seen = 1'b0;
    repeat (3) begin
      drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (p1_ov !== 1'b0) seen = 1'b1;
    end
    n_run++;
    if (seen) begin n_fail++; $display("FAIL post_reset_stale: got out_valid=1 want 0"); end
    drv(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b1);
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b1 || p1_s !== 16'h2345 || p1_co !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_first: got v=%b %b/%h want v=1 0/2345", p1_ov, p1_co, p1_s);
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_carry();
    drv(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    n_run++;
    if (p1_ir !== 1'b1) begin n_fail++; $display("FAIL carry_in_ready: got %b want 1", p1_ir); end
    drv(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b0) begin n_fail++; $display("FAIL carry_latency: got out_valid=%b want 0", p1_ov); end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b1 || p1_s !== 16'h0000 || p1_co !== 1'b1) begin
      n_fail++; $display("FAIL carry_all_blocks: got v=%b %b/%h want v=1 1/0000", p1_ov, p1_co, p1_s);
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b1 || p1_s !== 16'h8000 || p1_co !== 1'b0) begin
      n_fail++; $display("FAIL carry_to_msb: got v=%b %b/%h want v=1 0/8000", p1_ov, p1_co, p1_s);
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [3] = '{16'h0001, 16'h00F0, 16'hFFFF};
    logic [15:0] bv [3] = '{16'h0002, 16'h0010, 16'hFFFF};
    logic        cv [3] = '{1'b0, 1'b1, 1'b1};
    logic [16:0] ev [3] = '{17'h00003, 17'h00101, 17'h1FFFF};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv(1'b1, av[i], bv[i], cv[i], 1'b1);
      else       drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (i >= 2) begin
        n_run++;
        if (p1_ov !== 1'b1 || {p1_co, p1_s} !== ev[i-2]) begin
          n_fail++;
          $display("FAIL stream_%0d: got v=%b %b/%h want v=1 %h", i - 2, p1_ov, p1_co, p1_s, ev[i-2]);
        end
      end
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    drv(1'b1, 16'h0100, 16'h0023, 1'b0, 1'b0);
    n_run++;
    if (p1_ir !== 1'b1) begin n_fail++; $display("FAIL bp_accept_1: got %b want 1", p1_ir); end
    drv(1'b1, 16'h1000, 16'h0FFF, 1'b1, 1'b0);
    n_run++;
    if (p1_ir !== 1'b1) begin n_fail++; $display("FAIL bp_accept_2: got %b want 1", p1_ir); end
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 16'hABCD, 16'h5432, 1'b1, 1'b0);
      n_run++;
      if (p1_ir !== 1'b0 || p1_ov !== 1'b1 || p1_s !== 16'h0123 || p1_co !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b %b/%h want rdy=0 v=1 0/0123", i, p1_ir, p1_ov, p1_co, p1_s);
      end
    end
    drv(1'b1, 16'hABCD, 16'h5432, 1'b1, 1'b1);
    n_run++;
    if (p1_ir !== 1'b1 || p1_ov !== 1'b1 || p1_s !== 16'h0123) begin
      n_fail++; $display("FAIL bp_release: got rdy=%b v=%b sum=%h want rdy=1 v=1 0123", p1_ir, p1_ov, p1_s);
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b1 || {p1_co, p1_s} !== 17'h02000) begin
      n_fail++; $display("FAIL bp_second: got v=%b %b/%h want v=1 0/2000", p1_ov, p1_co, p1_s);
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b1 || {p1_co, p1_s} !== 17'h10000) begin
      n_fail++; $display("FAIL bp_third: got v=%b %b/%h want v=1 1/0000", p1_ov, p1_co, p1_s);
    end
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_run++;
    if (p1_ov !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got v=%b want 0", p1_ov); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    drv(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    drv(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0);
    drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_run++;
    if (p1_ov !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got v=%b want 1", p1_ov); end
    rst_n = 1'b0;
    #1;
    n_run++;
    if (p1_ov !== 1'b0 || p1_ir !== 1'b1) begin
      n_fail++; $display("FAIL mid_async_drop: got v=%b rdy=%b want v=0 rdy=1", p1_ov, p1_ir);
    end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      drv(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (p1_ov !== 1'b0) seen = 1'b1;
    end
    n_run++;
    if (seen) begin n_fail++; $display("FAIL mid_stale_result: got out_valid=1 want 0"); end
  endtask

  task automatic test_sweep();
    logic [16:0] q1 [$];
    logic [8:0]  q0 [$];
    logic [32:0] qw [$];
    logic [16:0] e1;
    logic [8:0]  e0;
    logic [32:0] ew;
    int acc1 = 0, emi1 = 0, acc0 = 0, emi0 = 0, accw = 0, emiw = 0;
    for (int cyc = 0; cyc < 4020; cyc++) begin
      @(negedge clk);
      if (cyc < 4000) begin
        p1_iv = ($urandom % 4) != 0; p1_or = ($urandom % 3) != 0;
        p0_iv = ($urandom % 3) != 0; p0_or = ($urandom % 4) != 0;
        w_iv  = ($urandom % 2) != 0; w_or  = ($urandom % 3) != 0;
      end else begin
        p1_iv = 1'b0; p1_or = 1'b1; p0_iv = 1'b0; p0_or = 1'b1; w_iv = 1'b0; w_or = 1'b1;
      end
      p1_a = 16'($urandom); p1_b = 16'($urandom); p1_ic = 1'($urandom);
      p0_a = 8'($urandom);  p0_b = 8'($urandom);  p0_ic = 1'($urandom);
      w_a  = $urandom;      w_b  = $urandom;      w_ic  = 1'($urandom);
      #1;
      if (p1_ov && p1_or) begin
        n_run++; emi1++;
        if (q1.size() == 0) begin n_fail++; $display("FAIL sweep_p1_extra: got %h want none", {p1_co, p1_s}); end
        else begin
          e1 = q1.pop_front();
          if ({p1_co, p1_s} !== e1) begin n_fail++; $display("FAIL sweep_p1: got %h want %h", {p1_co, p1_s}, e1); end
        end
      end
      if (p1_iv && p1_ir) begin q1.push_back({1'b0, p1_a} + {1'b0, p1_b} + {16'd0, p1_ic}); acc1++; end
      if (p0_ov && p0_or) begin
        n_run++; emi0++;
        if (q0.size() == 0) begin n_fail++; $display("FAIL sweep_p0_extra: got %h want none", {p0_co, p0_s}); end
        else begin
          e0 = q0.pop_front();
          if ({p0_co, p0_s} !== e0) begin n_fail++; $display("FAIL sweep_p0: got %h want %h", {p0_co, p0_s}, e0); end
        end
      end
      if (p0_iv && p0_ir) begin q0.push_back({1'b0, p0_a} + {1'b0, p0_b} + {8'd0, p0_ic}); acc0++; end
      if (w_ov && w_or) begin
        n_run++; emiw++;
        if (qw.size() == 0) begin n_fail++; $display("FAIL sweep_w_extra: got %h want none", {w_co, w_s}); end
        else begin
          ew = qw.pop_front();
          if ({w_co, w_s} !== ew) begin n_fail++; $display("FAIL sweep_w: got %h want %h", {w_co, w_s}, ew); end
        end
      end
      if (w_iv && w_ir) begin qw.push_back({1'b0, w_a} + {1'b0, w_b} + {32'd0, w_ic}); accw++; end
    end
    n_run++;
    if (acc1 != emi1 || acc0 != emi0 || accw != emiw) begin
      n_fail++;
      $display("FAIL sweep_counts: got emitted %0d/%0d/%0d want accepted %0d/%0d/%0d",
               emi1, emi0, emiw, acc1, acc0, accw);
    end
    n_run++;
    if (acc1 < 1000 || acc0 < 1000 || accw < 1000) begin
      n_fail++; $display("FAIL sweep_activity: got accepted %0d/%0d/%0d want >=1000 each", acc1, acc0, accw);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
